// File: rtl/xfer_sequencer.sv
// Transfer sequencer: pattern fill (write) or checksum scan (read) of LENGTH words over a valid/ready port.
// Optional abort on RUN[1] is built when XFER_SEQ_ABORT_EN is defined.
module xfer_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] MODE,
    input  logic [DATA_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] LENGTH,
    input  logic [DATA_WIDTH-1:0] RUN,
    output logic [DATA_WIDTH-1:0] STATUS,
    output logic [DATA_WIDTH-1:0] STATUS2,
    output logic [DATA_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_WE,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic                  MEM_VALID,
    input  logic                  MEM_READY,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    input  logic                  MEM_RVALID
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

    state_t                 state, state_next;
    logic                   run_q;
    logic                   op;
    logic [DATA_WIDTH-17:0] pattern;
    logic [DATA_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  length;
    logic [DATA_WIDTH-1:0]  issue_cnt;
    logic [3:0]             outstanding;
    logic [DATA_WIDTH-1:0]  status2;
    logic                   done, err, aborted, aborting;

    logic start, start_accept, abort_req;
    logic mem_valid, handshake, last, set_done, set_aborted;
    logic read_issue, read_return;

`ifdef XFER_SEQ_ABORT_EN
    assign abort_req = RUN[1];
    logic unused_bits;
    assign unused_bits = ^{MODE[15:1], RUN[DATA_WIDTH-1:2], ADDRESS[1:0]};
`else
    assign abort_req = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{MODE[15:1], RUN[DATA_WIDTH-1:1], ADDRESS[1:0]};
`endif

    assign start        = RUN[0] & ~run_q;
    assign start_accept = start && (state == S_IDLE);
    assign last         = (issue_cnt == length - 1'b1);
    assign read_issue   = handshake && !op;
    // Returns with nothing outstanding (e.g. after a reset) are dropped.
    assign read_return  = MEM_RVALID && (outstanding != 4'd0);

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_next  = state;
        mem_valid   = 1'b0;
        handshake   = 1'b0;
        set_done    = 1'b0;
        set_aborted = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (LENGTH != '0))
                    state_next = S_ISSUE;
            end
            S_ISSUE: begin
                mem_valid = op || (outstanding < OUT_MAX);
                handshake = mem_valid && MEM_READY;
                if (abort_req || (handshake && last))
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == 4'd0) begin
                    state_next  = S_IDLE;
                    set_done    = !aborting;
                    set_aborted = aborting;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            run_q       <= 1'b0;
            op          <= 1'b0;
            pattern     <= '0;
            addr        <= '0;
            length      <= '0;
            issue_cnt   <= '0;
            outstanding <= 4'd0;
            status2     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            aborted     <= 1'b0;
            aborting    <= 1'b0;
        end else begin
            run_q <= RUN[0];
            if (start_accept) begin
                op          <= MODE[0];
                pattern     <= MODE[DATA_WIDTH-1:16];
                addr        <= {ADDRESS[DATA_WIDTH-1:2], 2'b00};
                length      <= LENGTH;
                issue_cnt   <= '0;
                outstanding <= 4'd0;
                status2     <= '0;
                done        <= (LENGTH == '0);
                err         <= (LENGTH == '0);
                aborted     <= 1'b0;
                aborting    <= 1'b0;
            end else begin
                if (handshake) begin
                    addr      <= addr + 3'd4;
                    issue_cnt <= issue_cnt + 1'b1;
                end
                case ({read_issue, read_return})
                    2'b10:   outstanding <= outstanding + 4'd1;
                    2'b01:   outstanding <= outstanding - 4'd1;
                    default: outstanding <= outstanding;
                endcase
                if (op && handshake)
                    status2 <= status2 + 1'b1;
                else if (!op && read_return)
                    status2 <= status2 + MEM_RDATA;
                if (state == S_ISSUE && abort_req)
                    aborting <= 1'b1;
                if (set_done)
                    done <= 1'b1;
                if (set_aborted)
                    aborted <= 1'b1;
            end
        end
    end

    assign MEM_VALID = mem_valid;
    assign MEM_ADDR  = addr;
    assign MEM_WE    = op;
    assign MEM_WDATA = {pattern, issue_cnt[15:0]};
    assign STATUS    = {{(DATA_WIDTH-4){1'b0}}, aborted, err, done, (state != S_IDLE)};
    assign STATUS2   = status2;

endmodule

// File: doc/xfer_sequencer.md
# xfer_sequencer

Transfer sequencer driven by the MODE/ADDRESS/LENGTH/RUN control registers of the AXI-Lite register slave. It reports progress back through that slave's STATUS/STATUS2 read registers. On a start request it issues LENGTH word-sized memory requests, either a pattern fill (write) or a checksum scan (read), over a simple valid/ready memory port. Up to MAX_OUTSTANDING reads may be in flight at once.

## Interface
- DATA_WIDTH, 32: control, status and memory data width.
- MAX_OUTSTANDING, 4: maximum issued-but-unreturned reads; range 1..15.
- ACLK  in  1  single clock; all logic on posedge.
- ARESET  in  1  asynchronous, active-high reset.
- MODE  in  32  [0] op: 0 = read/checksum, 1 = write/fill; [31:16] fill pattern high half; other bits ignored.
- ADDRESS  in  32  start byte address; bits [1:0] ignored (forced 0).
- LENGTH  in  32  number of words to transfer.
- RUN  in  32  [0] start (rising edge); [1] abort (ABORT_EN builds only); other bits ignored.
- STATUS  out  32  [0] busy, [1] done, [2] zero-length error, [3] aborted, [31:4] 0.
- STATUS2  out  32  read op: running checksum; write op: count of accepted writes.
- MEM_ADDR  out  32  request byte address.
- MEM_WE  out  1  1 = write request.
- MEM_WDATA  out  32  write data.
- MEM_VALID  out  1  request valid.
- MEM_READY  in  1  request accepted when high with MEM_VALID.
- MEM_RDATA  in  32  read return data.
- MEM_RVALID  in  1  one read word returned (no backpressure).

## Operation
- Start detection:
  - run_q register holds the previous RUN[0]; start = RUN[0] & ~run_q.
  - A start while busy is ignored.
- On start in IDLE, latch op, pattern, address & ~3 and LENGTH.
  - Clear the STATUS done/err/aborted bits, STATUS2, the issue counter and the outstanding counter.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE -> ISSUE on start with LENGTH != 0.
  - IDLE stays IDLE on start with LENGTH == 0; done=1 and err=1 next cycle, and no MEM_VALID is ever raised.
  - ISSUE -> DRAIN on the handshake of the last request.
  - DRAIN -> IDLE once outstanding == 0. A write op has nothing outstanding, so it leaves DRAIN after 1 cycle.
  - Entering IDLE from DRAIN sets done=1.
- MEM_VALID = (state == ISSUE) && (op == write || outstanding < MAX_OUTSTANDING).
- While MEM_VALID is high and MEM_READY is low, MEM_ADDR, MEM_WE and MEM_WDATA stay stable.
- On each handshake:
  - Address advances by 4, wrapping modulo 2^32.
  - Issue count increments.
  - Write data for word index i is {pattern, i[15:0]}.
- Outstanding counter: +1 on a read handshake, -1 on MEM_RVALID, net 0 when both occur in the same cycle. MEM_RVALID with outstanding == 0 is ignored.
- Checksum: STATUS2 += MEM_RDATA on each counted MEM_RVALID, 32-bit wrap. In a write op, STATUS2 += 1 per accepted write.
- busy = (state != IDLE).
- done, err and aborted are sticky until the next accepted start.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and run_q cleared.
- Reset mid-transfer: MEM_VALID drops asynchronously and no further requests are issued. Returns arriving after reset release are ignored because outstanding = 0.
- Start latency: RUN[0] is sampled high in cycle N with run_q = 0; busy = 1 and MEM_VALID = 1 in cycle N+1.
- Throughput: 1 request per cycle while MEM_READY = 1 and the outstanding limit is not reached.
- Completion: done is set in the cycle after outstanding reaches 0 in DRAIN, and busy clears in that same cycle.
- A write of LENGTH words with MEM_READY tied high has done = 1 at cycle N+LENGTH+2.

## Configuration
- XFER_SEQ_ABORT_EN defined:
  - RUN[1] high in ISSUE stops issuing at once and moves to DRAIN; a handshake completing in that same cycle still counts.
  - RUN[1] high in DRAIN has no extra effect.
  - When outstanding reaches 0, the block returns to IDLE with aborted=1 and done=0.
- XFER_SEQ_ABORT_EN undefined: RUN[1] is ignored and STATUS[3] is constant 0.

## Test plan
- Write fill: MODE=0xAB000001, ADDRESS=0x100, LENGTH=4, MEM_READY=1, pulse RUN=1.
  - Required: writes to 0x100/0x104/0x108/0x10C with data 0xAB000000..0xAB000003; STATUS=0x2, STATUS2=4.
- Read checksum: MODE=0, LENGTH=3, memory returns 1, 2, 3 with 2-cycle latency.
  - Required: STATUS2=6, STATUS=0x2, outstanding returns to 0.
- Backpressure: LENGTH=8, MEM_READY toggling every cycle, returns delayed 10 cycles.
  - Required: outstanding never exceeds 4, MEM_ADDR/MEM_WE/MEM_WDATA stable while stalled, 8 returns counted.
- Edge cases:
  - LENGTH=0 -> STATUS=0x6 next cycle, MEM_VALID never high.
  - ADDRESS=0xFFFFFFFE, LENGTH=2 -> addresses 0xFFFFFFFC then 0x00000000.
  - RUN held high after completion -> no restart.
- Reset: assert ARESET mid-read with 3 outstanding.
  - Required: MEM_VALID and STATUS go to 0 immediately; late MEM_RVALID pulses leave STATUS2=0.
- Abort (XFER_SEQ_ABORT_EN): read LENGTH=16, RUN=0x3 after 5 handshakes.
  - Required: no further requests, all outstanding returns drained, then STATUS=0x8.
